// File: rtl/uart_rx_if.sv
// Receive-side bundle of the 8N1 UART receiver: serial line in, byte holding register out.
// The receiver drives through "master"; the consumer of received bytes uses "slave".
interface uart_rx_if;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    modport master (
        input  rx, rx_ready,
        output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
    );

    modport slave (
        output rx, rx_ready,
        input  rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 8x oversampling from an enable-tick divider, 3-sample majority vote,
// valid/ready holding register with framing-error and overrun pulses.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic      sys_clk,
    input  logic      reset,
    uart_rx_if.master bus
);
    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * 8);
    localparam int CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic [2:0]    state, state_next;
    logic          rx_meta, rx_s;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [2:0]    s_cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    smp;
    logic [7:0]    shreg;
    logic          maj;
    logic          deliver, frame_bad;
    logic [7:0]    data_q;
    logic          valid_q, ferr_q, ovr_q;

    function automatic logic vote(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign tick = (div_cnt == TICK_MAX);

    // The stop bit is judged in the same tick as its third sample, so that sample comes from rx_s.
    assign maj = (state == STOP) ? vote(smp[0], smp[1], rx_s) : vote(smp[0], smp[1], smp[2]);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        deliver    = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE:      if (!rx_s) state_next = START;
            START:     if (tick && s_cnt == 3'd7) state_next = maj ? IDLE : DATA;
            DATA:      if (tick && s_cnt == 3'd7 && bit_idx == 3'd7) state_next = STOP;
            STOP: begin
                if (tick && s_cnt == 3'd4) begin
                    if (maj) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state   <= IDLE;
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            div_cnt <= '0;
            s_cnt   <= '0;
            bit_idx <= '0;
            smp     <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
            state   <= state_next;

            // Restarting the divider on the start edge puts sample ticks at fixed offsets into each bit.
            if ((state == IDLE && !rx_s) || tick) div_cnt <= '0;
            else                                  div_cnt <= div_cnt + CW'(1);

            if (state_next != state) s_cnt <= '0;
            else if (tick)           s_cnt <= s_cnt + 3'd1;

            if (tick) begin
                case (s_cnt)
                    3'd2:    smp[0] <= rx_s;
                    3'd3:    smp[1] <= rx_s;
                    3'd4:    smp[2] <= rx_s;
                    default: ;
                endcase
            end

            if (state != DATA)                bit_idx <= '0;
            else if (tick && s_cnt == 3'd7)   bit_idx <= bit_idx + 3'd1;

            if (state == DATA && tick && s_cnt == 3'd7) shreg[bit_idx] <= maj;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= frame_bad;
            ovr_q  <= 1'b0;
            if (deliver) begin
                // A consumer accepting in the delivery cycle frees the register for the new byte.
                if (!valid_q || bus.rx_ready) begin
                    data_q  <= shreg;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_frame_err = ferr_q;
    assign bus.rx_overrun   = ovr_q;
    assign bus.rx_busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are driven bit by bit, expected outcomes are queued per frame
// and a negedge monitor matches every data/framing/overrun event against the queue.
module tb_uart_rx;
    localparam int CLK_FREQ  = 800;
    localparam int BAUD_RATE = 10;
    localparam int TICK_DIV  = CLK_FREQ / (BAUD_RATE * 8);
    localparam int BIT_CYC   = 8 * TICK_DIV;
    localparam int LAT       = 77 * TICK_DIV + 3;

    typedef enum logic [1:0] {EV_DATA, EV_FERR, EV_OVR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    uart_rx_if bus ();

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    bit   model_full = 1'b0;
    time  t_start = 0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp_v, input int tol);
        checks++;
        if (act < exp_v - tol || act > exp_v + tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d (t=%0t)", name, act, exp_v, tol, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    // Outcome follows the receiver's rules: bad stop bit -> framing error; otherwise the byte
    // lands if the holding register is empty or is being accepted at that moment, else overrun.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input bit ready_at_delivery, input int glitch_idx);
        ev_t        e;
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        if (!stop) begin
            e = '{EV_FERR, 8'h00};
        end else if (!model_full || ready_at_delivery) begin
            e = '{EV_DATA, b};
            model_full = 1'b1;
        end else begin
            e = '{EV_OVR, 8'h00};
        end
        exp_q.push_back(e);
        t_start = $time;
        for (int i = 0; i < 10; i++) begin
            bus.rx = fr[i];
            if (i == glitch_idx) begin
                cyc(24);
                bus.rx = ~fr[i];
                cyc(10);
                bus.rx = fr[i];
                cyc(BIT_CYC - 34);
            end else begin
                cyc(BIT_CYC);
            end
        end
    endtask

    task automatic consume();
        bus.rx_ready = 1'b1;
        cyc(1);
        bus.rx_ready = 1'b0;
        model_full   = 1'b0;
        cyc(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(bus.rx_data),      32'h00);
        check({tag, "_valid"}, 32'(bus.rx_valid),     32'd0);
        check({tag, "_ferr"},  32'(bus.rx_frame_err), 32'd0);
        check({tag, "_ovr"},   32'(bus.rx_overrun),   32'd0);
        check({tag, "_busy"},  32'(bus.rx_busy),      32'd0);
    endtask

    initial begin : monitor
        ev_t got;
        ev_t want;
        bit  have;
        int  lat;
        forever begin
            @(negedge sys_clk);
            have = 1'b0;
            if (bus.rx_frame_err === 1'b1) begin
                got = '{EV_FERR, 8'h00};
                have = 1'b1;
            end else if (bus.rx_overrun === 1'b1) begin
                got = '{EV_OVR, 8'h00};
                have = 1'b1;
            end else if (bus.rx_valid === 1'b1 && (!prev_valid || prev_ready)) begin
                got = '{EV_DATA, bus.rx_data};
                have = 1'b1;
            end
            if (have) begin
                check("sb_event_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    lat  = int'(($time - t_start) / 10);
                    check("sb_kind", 32'(got.kind), 32'(want.kind));
                    if (want.kind == EV_DATA) check("sb_data", 32'(got.data), 32'(want.data));
                    check_tol("sb_latency", lat, LAT, 2);
                end
            end
            prev_valid = bus.rx_valid;
            prev_ready = bus.rx_ready;
        end
    end

    initial begin : stimulus
        logic [7:0] pb;
        logic [7:0] rb;
        logic       rstop;
        bus.rx       = 1'b1;
        bus.rx_ready = 1'b0;
        reset        = 1'b0;
        cyc(3);
        check_reset_outputs("por");
        reset = 1'b1;
        cyc(20);

        // Plain frame, held until accepted
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        check("a5_valid", 32'(bus.rx_valid), 32'd1);
        check("a5_data",  32'(bus.rx_data),  32'hA5);
        cyc(200);
        check("a5_held", 32'(bus.rx_valid), 32'd1);
        consume();
        check("a5_consumed", 32'(bus.rx_valid), 32'd0);
        check("a5_data_kept", 32'(bus.rx_data), 32'hA5);
        cyc(30);

        // False start: 15-cycle low pulse
        bus.rx = 1'b0;
        cyc(4);
        check("fs_busy_rise", 32'(bus.rx_busy), 32'd1);
        cyc(11);
        bus.rx = 1'b1;
        cyc(67);
        check("fs_busy_before_8ticks", 32'(bus.rx_busy), 32'd1);
        cyc(1);
        check("fs_busy_after_8ticks", 32'(bus.rx_busy), 32'd0);
        cyc(50);
        check("fs_no_valid", 32'(bus.rx_valid), 32'd0);

        // Framing error followed by a held-low break
        send_frame(8'h00, 1'b0, 1'b0, -1);
        cyc(200);
        check("fe_wait_busy", 32'(bus.rx_busy), 32'd1);
        check("fe_no_valid", 32'(bus.rx_valid), 32'd0);
        bus.rx = 1'b1;
        cyc(5);
        check("fe_release_idle", 32'(bus.rx_busy), 32'd0);
        cyc(20);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        check("fe_next_data", 32'(bus.rx_data), 32'h3C);
        consume();
        cyc(20);

        // Back-to-back frames, consumer asleep
        send_frame(8'h55, 1'b1, 1'b0, -1);
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        check("ovr_data_kept", 32'(bus.rx_data),  32'h55);
        check("ovr_valid",     32'(bus.rx_valid), 32'd1);
        consume();
        cyc(20);

        // Back-to-back frames, consumer accepts exactly in the second delivery cycle
        send_frame(8'h55, 1'b1, 1'b0, -1);
        fork
            send_frame(8'hC3, 1'b1, 1'b1, -1);
            begin
                cyc(LAT - 1);
                bus.rx_ready = 1'b1;
                cyc(1);
                bus.rx_ready = 1'b0;
            end
        join
        check("acc_data",  32'(bus.rx_data),  32'hC3);
        check("acc_valid", 32'(bus.rx_valid), 32'd1);
        consume();
        cyc(20);

        // Single-sample glitch on data bit 3
        send_frame(8'h0F, 1'b1, 1'b0, 4);
        check("glitch_data", 32'(bus.rx_data), 32'h0F);
        consume();
        cyc(20);

        // Reset in the middle of data bit 4, with a byte still held
        send_frame(8'h96, 1'b1, 1'b0, -1);
        pb = 8'h5A;
        bus.rx = 1'b0;
        cyc(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            bus.rx = pb[i];
            cyc(BIT_CYC);
        end
        bus.rx = pb[4];
        cyc(BIT_CYC / 2);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        bus.rx     = 1'b1;
        model_full = 1'b0;
        cyc(5);
        reset = 1'b1;
        cyc(20);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        check("post_rst_data",  32'(bus.rx_data),  32'h81);
        check("post_rst_valid", 32'(bus.rx_valid), 32'd1);
        consume();
        cyc(20);

        // Random bytes, random consumer behaviour, occasional bad stop bit
        for (int k = 0; k < 10; k++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            send_frame(rb, rstop, 1'b0, -1);
            if (!rstop) begin
                cyc(30);
                bus.rx = 1'b1;
                cyc(5);
            end
            if ($urandom_range(0, 1) == 1) consume();
            cyc($urandom_range(0, 30));
        end

        consume();
        cyc(50);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART serial receiver for 8N1 frames, sitting beside `baud_gen` on the same `sys_clk` domain. It is the receiving end of the serial link that the baud generator paces. It oversamples the line at 8× the baud rate with an internal enable-tick divider, so no generated clock is used as a clock. Each bit is recovered by majority vote. Received bytes are presented on a valid/ready holding register, with framing-error and overrun indications.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, serial bit rate in bits/s.
- Derived: `TICK_DIV = CLK_FREQ / (BAUD_RATE*8)` (integer division); must be ≥ 2. The divider counter width is `$clog2(TICK_DIV)`.
- `sys_clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  asynchronous serial line; idle high.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid & rx_ready`.
- `rx_data`  out  8  last received byte, LSB first on the wire.
- `rx_valid`  out  1  holding register full; held until accepted.
- `rx_frame_err`  out  1  one-cycle pulse when a sampled stop bit is 0.
- `rx_overrun`  out  1  one-cycle pulse when a completed byte is dropped.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- Synchronizer: two flops (`rx` → `rx_s`), both reset to 1. All decisions use `rx_s`.
- Tick divider: counts 0..TICK_DIV-1 and asserts `tick` for one cycle when the count equals TICK_DIV-1. It is forced to 0 on the IDLE→START transition, which aligns ticks to the start edge.
- Sub-bit counter `s` (3 bits) advances on each `tick`. It is cleared on every state transition.
- Sampling: on ticks with `s` = 2, 3 and 4, store `rx_s`. The bit value is the majority of the three samples.
- States:
  - IDLE: when `rx_s`==0, go to START.
  - START: on the tick with `s`==7, go to DATA with bit index 0 if the majority is 0. If the majority is 1 (false start), go to IDLE with no output.
  - DATA: on each tick with `s`==7, shift the majority bit into the shift register at bit[index] (LSB first). After index 7, go to STOP.
  - STOP: decide on the tick with `s`==4, right after the third sample. This leaves 3 ticks of margin for back-to-back frames.
    - Majority 1: deliver the byte, then go to IDLE.
    - Majority 0: pulse `rx_frame_err`, do not deliver, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This prevents a break condition from retriggering START.
- Delivery:
  - If `rx_valid`==0, or `rx_valid & rx_ready` in the same cycle: load `rx_data` and set `rx_valid`=1.
  - Otherwise: drop the new byte, keep `rx_data` unchanged, and pulse `rx_overrun`.
- Consumption: `rx_valid & rx_ready` with no simultaneous delivery clears `rx_valid` on the next edge. `rx_data` keeps its value.
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE.
  - All counters and the shift register go to 0; the synchronizer goes to 1.
  - `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_overrun`=0, `rx_busy`=0.

## Timing
- Tick period: TICK_DIV cycles. Bit period: 8 ticks.
- Samples fall at 3, 4 and 5 ticks after the start edge is detected; the 4-tick point is the nominal bit centre.
- `rx_valid` rises 77×TICK_DIV + 3 `sys_clk` cycles after `rx` is first sampled low at the start edge. This is 2 synchronizer cycles plus 1 IDLE detect cycle plus 77 ticks. Bench tolerance is ±2 cycles.
- `rx_frame_err` and `rx_overrun` are asserted for exactly one cycle, in the cycle where `rx_valid` would otherwise have been updated.
- `rx_busy` rises 1 cycle after `rx_s` first reads low in IDLE. It falls in the cycle the state returns to IDLE.
- Tolerated baud mismatch is about ±3% because of the centre sampling and the early stop-bit decision.

## Test plan
Use `CLK_FREQ`=800 and `BAUD_RATE`=10, giving TICK_DIV=10 and an 80-cycle bit.
- Send 0xA5 in 8N1 with `rx_ready`=0. Required: `rx_data`=0xA5, `rx_valid`=1 at the latency above, and `rx_valid` held until `rx_ready` is pulsed for 1 cycle, then 0. `rx_frame_err` stays 0.
- Pulse `rx` low for 15 cycles while idle. Required: false start, no `rx_valid`, no error, and `rx_busy` returns to 0 after 8 ticks.
- Send 0x00 with the stop bit driven low, hold low for 200 cycles, then drive high. Required: one `rx_frame_err` pulse, `rx_valid` stays 0, and no new frame starts until `rx` goes high. A following 0x3C is received correctly.
- Send back-to-back 0x55 then 0xC3 with `rx_ready`=0. Required: `rx_data`=0x55, one `rx_overrun` pulse, and 0xC3 dropped. Repeat with `rx_ready` asserted exactly in the second delivery cycle. Required: `rx_data`=0xC3 and no overrun.
- Invert `rx` for 10 cycles around the s=2 sample of data bit 3 while sending 0x0F. Required: the majority vote rejects the glitch and `rx_data`=0x0F.
- Assert `reset` in the middle of data bit 4 of a frame. Required: all outputs read their reset values immediately. After release, a clean 0x81 frame gives `rx_data`=0x81 with no errors.
